branch_feedback_queue: RTL and testbench
========================================

BRANCH_FEEDBACK_QUEUE -- requirements
Module: branch_feedback_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of branch PC.
REQ-002 SHALL have parameter QUEUE_SIZE_LOG, default 3, giving QUEUE_SIZE = 1 << QUEUE_SIZE_LOG entries.
REQ-003 SHALL have parameter STAT_WIDTH, default 16, width of the statistics counters.
REQ-004 SHALL have port Sys_clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Sys_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port Sys_rdy  input  1  global enable; low freezes all state.
REQ-007 SHALL have port IFBQ_push_en  input  1  instruction fetcher records one predicted conditional branch.
REQ-008 SHALL have port IFBQ_pc  input  ADDR_WIDTH  PC of the pushed branch.
REQ-009 SHALL have port IFBQ_predict  input  1  prediction given by the predictor (1 = taken).
REQ-010 SHALL have port EXBQ_resolve_en  input  1  the oldest outstanding branch has resolved.
REQ-011 SHALL have port EXBQ_taken  input  1  actual outcome of that branch (1 = taken).
REQ-012 SHALL have port BQIF_full  output  1  queue holds QUEUE_SIZE entries; fetcher stalls branches.
REQ-013 SHALL have port BQIF_mispredict  output  1  one-cycle pulse, head branch was mispredicted.
REQ-014 SHALL have port BQPD_feedback_en  output  1  one-cycle pulse driving the predictor feedback enable.
REQ-015 SHALL have port BQPD_feedback_pc  output  ADDR_WIDTH  PC of the resolved branch.
REQ-016 SHALL have port BQPD_branch_result  output  1  actual outcome sent to the predictor.
REQ-017 SHALL have port BQ_count  output  QUEUE_SIZE_LOG+1  number of valid entries.
REQ-018 SHALL have ports BQ_branch_cnt and BQ_miss_cnt  output  STAT_WIDTH  resolved-branch and misprediction counts.

Function
REQ-019 SHALL store entries {pc, predict} in a circular buffer with head and tail pointers of QUEUE_SIZE_LOG bits; both wrap modulo QUEUE_SIZE.
REQ-020 SHALL accept a push when IFBQ_push_en=1 and count<QUEUE_SIZE, writing at tail and incrementing tail.
REQ-021 SHALL silently drop a push while full; no state changes from it.
REQ-022 SHALL process a resolve when EXBQ_resolve_en=1 and count>0: on the next edge drive BQPD_feedback_en=1, BQPD_feedback_pc=head pc, BQPD_branch_result=EXBQ_taken, and advance head.
REQ-023 SHALL ignore a resolve while empty; no feedback pulse, no counter change.
REQ-024 SHALL assert BQIF_mispredict for exactly one cycle, registered in the same edge as the feedback pulse, when head predict != EXBQ_taken.
REQ-025 SHALL, on a mispredict, flush all entries younger than the head (tail := new head, count := 0) in the same edge; a push in that same cycle is discarded.
REQ-026 SHALL, on simultaneous push and correct-prediction resolve, perform both; count unchanged; accepted even when full, since the resolve frees a slot in the same edge.
REQ-027 SHALL derive BQIF_full combinationally from count==QUEUE_SIZE.
REQ-028 SHALL increment BQ_branch_cnt on every processed resolve and BQ_miss_cnt on every mispredict; both saturate at all-ones.
REQ-029 SHALL hold BQPD_feedback_en and BQIF_mispredict at 0 on every cycle without a processed resolve; data outputs hold last value.
REQ-030 SHALL, while Sys_rdy=0, ignore push and resolve, hold all state, and drive both pulses to 0.

Reset
REQ-031 SHALL, on Sys_rst=1, immediately clear head, tail, count, both statistics counters, BQPD_feedback_en, BQIF_mispredict, BQPD_feedback_pc, BQPD_branch_result.
REQ-032 SHALL discard all queued entries on reset, including mid-operation; entry storage contents need not be cleared.

Verification
REQ-033 Push pc 0x100 predict 1, then resolve taken=1 -> next cycle feedback_en=1, feedback_pc=0x100, result=1, mispredict=0, count=0, branch_cnt=1.
REQ-034 Push 8 branches (default) -> full=1, count=8; 9th push dropped; 8 correct resolves return PCs in push order, wrapping pointers.
REQ-035 Push 3 (first predict 0), resolve taken=1 -> mispredict=1 one cycle, feedback_pc=first PC, count=0, miss_cnt=1; later resolve produces no pulse.
REQ-036 When full, push and correct resolve in the same cycle -> push accepted, count stays 8; with mispredicting resolve -> count=0, push discarded.
REQ-037 Resolve on empty -> no pulses, counters unchanged; Sys_rdy=0 with push+resolve -> no state change.
REQ-038 Assert Sys_rst between clock edges with 5 entries queued -> count=0 and pulses 0 immediately, before next edge.

Source files
------------

// File: rtl/branch_feedback_queue.sv
// Branch feedback queue: holds predicted conditional branches in fetch order and
// returns each one's actual outcome to the predictor when execution resolves it.
module branch_feedback_queue #(
    parameter int ADDR_WIDTH     = 32,
    parameter int QUEUE_SIZE_LOG = 3,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                      Sys_clk,
    input  logic                      Sys_rst,
    input  logic                      Sys_rdy,
    input  logic                      IFBQ_push_en,
    input  logic [ADDR_WIDTH-1:0]     IFBQ_pc,
    input  logic                      IFBQ_predict,
    input  logic                      EXBQ_resolve_en,
    input  logic                      EXBQ_taken,
    output logic                      BQIF_full,
    output logic                      BQIF_mispredict,
    output logic                      BQPD_feedback_en,
    output logic [ADDR_WIDTH-1:0]     BQPD_feedback_pc,
    output logic                      BQPD_branch_result,
    output logic [QUEUE_SIZE_LOG:0]   BQ_count,
    output logic [STAT_WIDTH-1:0]     BQ_branch_cnt,
    output logic [STAT_WIDTH-1:0]     BQ_miss_cnt
);

    localparam int QUEUE_SIZE = 1 << QUEUE_SIZE_LOG;
    localparam logic [QUEUE_SIZE_LOG-1:0] PTR_ONE  = QUEUE_SIZE_LOG'(1);
    localparam logic [QUEUE_SIZE_LOG:0]   CNT_ONE  = (QUEUE_SIZE_LOG + 1)'(1);
    localparam logic [QUEUE_SIZE_LOG:0]   FULL_CNT = {1'b1, {QUEUE_SIZE_LOG{1'b0}}};
    localparam logic [STAT_WIDTH-1:0]     STAT_ONE = STAT_WIDTH'(1);

    logic [ADDR_WIDTH-1:0]     pc_mem_q   [QUEUE_SIZE];
    logic                      pred_mem_q [QUEUE_SIZE];

    logic [QUEUE_SIZE_LOG-1:0] head_q, head_d;
    logic [QUEUE_SIZE_LOG-1:0] tail_q, tail_d;
    logic [QUEUE_SIZE_LOG:0]   count_q, count_d;
    logic [STAT_WIDTH-1:0]     branch_cnt_q, branch_cnt_d;
    logic [STAT_WIDTH-1:0]     miss_cnt_q, miss_cnt_d;
    logic                      fb_en_q, fb_en_d;
    logic                      miss_q, miss_d;
    logic [ADDR_WIDTH-1:0]     fb_pc_q, fb_pc_d;
    logic                      result_q, result_d;

    logic                      full_s;
    logic                      resolve_ok_s;
    logic                      miss_s;
    logic                      push_ok_s;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        if (v == {STAT_WIDTH{1'b1}}) begin
            return v;
        end else begin
            return v + STAT_ONE;
        end
    endfunction

    assign full_s = (count_q == FULL_CNT);

    // Qualify the requests; a resolve that mispredicts flushes the queue and eats any same-cycle push
    always_comb begin
        resolve_ok_s = Sys_rdy && EXBQ_resolve_en && (count_q != '0);
        miss_s       = resolve_ok_s && (pred_mem_q[head_q] != EXBQ_taken);
        push_ok_s    = Sys_rdy && IFBQ_push_en && !miss_s && (!full_s || resolve_ok_s);
    end

    // Next-state for pointers, occupancy, statistics and the registered outputs
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        fb_en_d      = 1'b0;
        miss_d       = 1'b0;
        fb_pc_d      = fb_pc_q;
        result_d     = result_q;

        if (resolve_ok_s) begin
            head_d       = head_q + PTR_ONE;
            fb_en_d      = 1'b1;
            fb_pc_d      = pc_mem_q[head_q];
            result_d     = EXBQ_taken;
            branch_cnt_d = sat_inc(branch_cnt_q);
        end else begin
            head_d = head_q;
        end

        if (miss_s) begin
            tail_d     = head_q + PTR_ONE;
            count_d    = '0;
            miss_d     = 1'b1;
            miss_cnt_d = sat_inc(miss_cnt_q);
        end else begin
            if (push_ok_s) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            case ({push_ok_s, resolve_ok_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control and status state; reset drops every queued entry at once
    always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
            fb_en_q      <= 1'b0;
            miss_q       <= 1'b0;
            fb_pc_q      <= '0;
            result_q     <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            fb_en_q      <= fb_en_d;
            miss_q       <= miss_d;
            fb_pc_q      <= fb_pc_d;
            result_q     <= result_d;
        end
    end

    // Entry storage needs no reset: occupancy alone says which slots are live
    always_ff @(posedge Sys_clk) begin
        if (push_ok_s) begin
            pc_mem_q[tail_q]   <= IFBQ_pc;
            pred_mem_q[tail_q] <= IFBQ_predict;
        end
    end

    assign BQIF_full          = full_s;
    assign BQIF_mispredict    = miss_q;
    assign BQPD_feedback_en   = fb_en_q;
    assign BQPD_feedback_pc   = fb_pc_q;
    assign BQPD_branch_result = result_q;
    assign BQ_count           = count_q;
    assign BQ_branch_cnt      = branch_cnt_q;
    assign BQ_miss_cnt        = miss_cnt_q;

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Directed bench for branch_feedback_queue with hand-computed expectations.
module tb_branch_feedback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        push_en;
    logic [31:0] pc;
    logic        pred;
    logic        res_en;
    logic        taken;
    logic        full;
    logic        mispredict;
    logic        fb_en;
    logic [31:0] fb_pc;
    logic        result;
    logic [3:0]  count;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;

    int errors = 0;
    int checks = 0;

    branch_feedback_queue dut (
        .Sys_clk            (clk),
        .Sys_rst            (rst),
        .Sys_rdy            (rdy),
        .IFBQ_push_en       (push_en),
        .IFBQ_pc            (pc),
        .IFBQ_predict       (pred),
        .EXBQ_resolve_en    (res_en),
        .EXBQ_taken         (taken),
        .BQIF_full          (full),
        .BQIF_mispredict    (mispredict),
        .BQPD_feedback_en   (fb_en),
        .BQPD_feedback_pc   (fb_pc),
        .BQPD_branch_result (result),
        .BQ_count           (count),
        .BQ_branch_cnt      (branch_cnt),
        .BQ_miss_cnt        (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests (inputs change between edges), sample #1 after the edge
    task automatic cycle(input logic p, input logic [31:0] a, input logic pr,
                         input logic r, input logic t);
        push_en = p; pc = a; pred = pr; res_en = r; taken = t;
        @(posedge clk);
        #1;
        push_en = 1'b0; res_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; push_en = 1'b0; pc = 32'h0; pred = 1'b0;
        res_en = 1'b0; taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_fb_en", 64'(fb_en), 64'd0);
        check("rst_branch_cnt", 64'(branch_cnt), 64'd0);
        rst = 1'b0;

        // Single push then correct resolve
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        check("t1_count_after_push", 64'(count), 64'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("t1_fb_en", 64'(fb_en), 64'd1);
        check("t1_fb_pc", 64'(fb_pc), 64'h100);
        check("t1_result", 64'(result), 64'd1);
        check("t1_mispredict", 64'(mispredict), 64'd0);
        check("t1_count", 64'(count), 64'd0);
        check("t1_branch_cnt", 64'(branch_cnt), 64'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t1_fb_en_drop", 64'(fb_en), 64'd0);

        // Fill to eight, overflow push dropped, drain in order across the wrap
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h200 + 32'(4 * i), 1'(i), 1'b0, 1'b0);
        check("t2_full", 64'(full), 64'd1);
        check("t2_count", 64'(count), 64'd8);
        cycle(1'b1, 32'h999, 1'b1, 1'b0, 1'b0);
        check("t2_drop_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'(i));
            check("t2_fb_pc", 64'(fb_pc), 64'h200 + 64'(4 * i));
            check("t2_no_miss", 64'(mispredict), 64'd0);
        end
        check("t2_count_empty", 64'(count), 64'd0);
        check("t2_branch_cnt", 64'(branch_cnt), 64'd9);

        // Mispredict on the head flushes the younger entries
        cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h308, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("t3_mispredict", 64'(mispredict), 64'd1);
        check("t3_fb_pc", 64'(fb_pc), 64'h300);
        check("t3_count", 64'(count), 64'd0);
        check("t3_miss_cnt", 64'(miss_cnt), 64'd1);
        check("t3_branch_cnt", 64'(branch_cnt), 64'd10);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t3_miss_drop", 64'(mispredict), 64'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("t3_late_fb_en", 64'(fb_en), 64'd0);
        check("t3_late_branch_cnt", 64'(branch_cnt), 64'd10);

        // Full queue: push with correct resolve is accepted, with a mispredict it is discarded
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
        check("t4_full", 64'(full), 64'd1);
        cycle(1'b1, 32'h500, 1'b1, 1'b1, 1'b1);
        check("t4_both_fb_pc", 64'(fb_pc), 64'h400);
        check("t4_both_count", 64'(count), 64'd8);
        check("t4_both_full", 64'(full), 64'd1);
        cycle(1'b1, 32'h600, 1'b1, 1'b1, 1'b0);
        check("t4_miss", 64'(mispredict), 64'd1);
        check("t4_miss_fb_pc", 64'(fb_pc), 64'h404);
        check("t4_miss_count", 64'(count), 64'd0);
        check("t4_miss_cnt", 64'(miss_cnt), 64'd2);
        cycle(1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("t4_after_fb_pc", 64'(fb_pc), 64'h700);
        check("t4_after_result", 64'(result), 64'd0);
        check("t4_branch_cnt", 64'(branch_cnt), 64'd13);

        // Sys_rdy low freezes everything
        cycle(1'b1, 32'h800, 1'b1, 1'b0, 1'b0);
        rdy = 1'b0;
        cycle(1'b1, 32'h900, 1'b1, 1'b1, 1'b1);
        check("t5_frozen_count", 64'(count), 64'd1);
        check("t5_frozen_fb_en", 64'(fb_en), 64'd0);
        check("t5_frozen_branch_cnt", 64'(branch_cnt), 64'd13);
        check("t5_frozen_fb_pc", 64'(fb_pc), 64'h700);
        rdy = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("t5_fb_pc", 64'(fb_pc), 64'h800);
        check("t5_branch_cnt", 64'(branch_cnt), 64'd14);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("t5_empty_fb_en", 64'(fb_en), 64'd0);
        check("t5_empty_miss", 64'(mispredict), 64'd0);
        check("t5_empty_branch_cnt", 64'(branch_cnt), 64'd14);
        check("t5_empty_miss_cnt", 64'(miss_cnt), 64'd2);

        // Asynchronous reset between edges with five entries queued and a live pulse
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'hA00 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("t6_pre_count", 64'(count), 64'd5);
        check("t6_pre_fb_en", 64'(fb_en), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_count", 64'(count), 64'd0);
        check("t6_rst_fb_en", 64'(fb_en), 64'd0);
        check("t6_rst_fb_pc", 64'(fb_pc), 64'd0);
        check("t6_rst_branch_cnt", 64'(branch_cnt), 64'd0);
        check("t6_rst_miss_cnt", 64'(miss_cnt), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b1, 32'hB00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("t6_post_fb_pc", 64'(fb_pc), 64'hB00);
        check("t6_post_count", 64'(count), 64'd0);
        check("t6_post_branch_cnt", 64'(branch_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
